// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares one register-file write port between the ALU
// writeback stream and MEM load returns.
//   clk, rst            : clock, synchronous active-high reset
//   alu_wb_*            : ALU result (no backpressure)
//   mem_wb_* / ready    : MEM load return (valid/ready)
//   rf_*                : registered register-file write
//   alu_throttle        : tells the Scheduler to hold off ALU RegWrite grants
//   fifo_count          : ALU skid FIFO occupancy
//   overflow            : sticky flag, an ALU result was dropped
module wb_port_arbiter #(
  parameter int DATA_W       = 256,
  parameter int REG_AW       = 5,
  parameter int WARP_W       = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int THROTTLE_LVL = 2,
  parameter int STARVE_MAX   = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_wb_valid,
  input  logic [WARP_W-1:0]             alu_wb_warp,
  input  logic [REG_AW-1:0]             alu_wb_rd,
  input  logic [DATA_W-1:0]             alu_wb_data,
  input  logic                          mem_wb_valid,
  output logic                          mem_wb_ready,
  input  logic [WARP_W-1:0]             mem_wb_warp,
  input  logic [REG_AW-1:0]             mem_wb_rd,
  input  logic [DATA_W-1:0]             mem_wb_data,
  output logic                          rf_we,
  output logic [WARP_W-1:0]             rf_warp,
  output logic [REG_AW-1:0]             rf_addr,
  output logic [DATA_W-1:0]             rf_data,
  output logic                          alu_throttle,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [WARP_W-1:0] warp;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_t;

  wb_t             fifo_q [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [SW-1:0]   starve_cnt;

  wb_t             alu_in;
  wb_t             mem_in;
  wb_t             alu_cand;
  logic            fifo_empty;
  logic            fifo_full;
  logic            alu_pend;
  logic            force_alu;
  logic            win_alu;
  logic            win_mem;
  logic            pop;
  logic            push;
  logic            do_push;
  logic            drop;

  assign alu_in = '{warp: alu_wb_warp, rd: alu_wb_rd, data: alu_wb_data};
  assign mem_in = '{warp: mem_wb_warp, rd: mem_wb_rd, data: mem_wb_data};

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));

  // FIFO head takes priority over the live input so ALU order is kept.
  assign alu_pend = !fifo_empty || alu_wb_valid;
  assign alu_cand = fifo_empty ? alu_in : fifo_q[rd_ptr];

  assign force_alu    = alu_pend && (starve_cnt == SW'(STARVE_MAX));
  assign mem_wb_ready = !rst && !force_alu;

  assign win_mem = mem_wb_valid && !force_alu;
  assign win_alu = force_alu || (!mem_wb_valid && alu_pend);

  // Live ALU result is queued whenever it is not the one being written.
  assign pop     = win_alu && !fifo_empty;
  assign push    = alu_wb_valid && (!fifo_empty || win_mem);
  assign do_push = push && (!fifo_full || pop);
  assign drop    = push && fifo_full && !pop;

  assign alu_throttle = (fifo_count >= CW'(THROTTLE_LVL));

  // Storage needs no reset; count and pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      fifo_q[wr_ptr] <= alu_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (win_alu || !alu_pend) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SW'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we   <= 1'b0;
      rf_warp <= '0;
      rf_addr <= '0;
      rf_data <= '0;
    end else begin
      rf_we <= win_mem || win_alu;
      if (win_mem) begin
        rf_warp <= mem_in.warp;
        rf_addr <= mem_in.rd;
        rf_data <= mem_in.data;
      end else if (win_alu) begin
        rf_warp <= alu_cand.warp;
        rf_addr <= alu_cand.rd;
        rf_data <= alu_cand.data;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed vectors against wb_port_arbiter
// with default parameters (FIFO_DEPTH=4, THROTTLE_LVL=2, STARVE_MAX=3).
module tb_wb_port_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         alu_wb_valid;
  logic [1:0]   alu_wb_warp;
  logic [4:0]   alu_wb_rd;
  logic [255:0] alu_wb_data;
  logic         mem_wb_valid;
  logic         mem_wb_ready;
  logic [1:0]   mem_wb_warp;
  logic [4:0]   mem_wb_rd;
  logic [255:0] mem_wb_data;
  logic         rf_we;
  logic [1:0]   rf_warp;
  logic [4:0]   rf_addr;
  logic [255:0] rf_data;
  logic         alu_throttle;
  logic [2:0]   fifo_count;
  logic         overflow;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_port_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .alu_wb_valid (alu_wb_valid),
    .alu_wb_warp  (alu_wb_warp),
    .alu_wb_rd    (alu_wb_rd),
    .alu_wb_data  (alu_wb_data),
    .mem_wb_valid (mem_wb_valid),
    .mem_wb_ready (mem_wb_ready),
    .mem_wb_warp  (mem_wb_warp),
    .mem_wb_rd    (mem_wb_rd),
    .mem_wb_data  (mem_wb_data),
    .rf_we        (rf_we),
    .rf_warp      (rf_warp),
    .rf_addr      (rf_addr),
    .rf_data      (rf_data),
    .alu_throttle (alu_throttle),
    .fifo_count   (fifo_count),
    .overflow     (overflow)
  );

  function automatic logic [255:0] alu_dat(input logic [4:0] rd);
    return {8{8'hA0, 19'h0, rd}};
  endfunction

  function automatic logic [255:0] mem_dat(input logic [4:0] rd);
    return {8{8'hB0, 19'h0, rd}};
  endfunction

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard,
                       input logic mv, input logic [4:0] mrd);
    alu_wb_valid = av;
    alu_wb_rd    = ard;
    alu_wb_warp  = ard[1:0];
    alu_wb_data  = alu_dat(ard);
    mem_wb_valid = mv;
    mem_wb_rd    = mrd;
    mem_wb_warp  = ~mrd[1:0];
    mem_wb_data  = mem_dat(mrd);
    #1;
  endtask

  // Inputs change 1 time unit after the edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write expected on the rf port after the last edge.
  task automatic chk_wr(input string tag, input logic [4:0] rd);
    chk({tag, ".we"}, rf_we, 1'b1);
    chk({tag, ".addr"}, rf_addr, rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    chk("rst.ready", mem_wb_ready, 1'b0);
    tick();
    tick();
    chk("rst.we", rf_we, 1'b0);
    chk("rst.addr", rf_addr, 5'd0);
    chk("rst.data", rf_data, 256'd0);
    chk("rst.count", fifo_count, 3'd0);
    chk("rst.ovf", overflow, 1'b0);
    chk("rst.thr", alu_throttle, 1'b0);
    rst = 1'b0;
    #1;

    // ALU-only stream: direct bypass, 1-cycle latency, in order
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 5'(i), 1'b0, 5'd0);
      chk("alu.ready", mem_wb_ready, 1'b1);
      tick();
      chk_wr("alu", 5'(i));
      chk("alu.count", fifo_count, 3'd0);
    end
    chk("alu.warp", rf_warp, 2'd1);
    chk("alu.data", rf_data, alu_dat(5'd5));
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    chk("idle.we", rf_we, 1'b0);
    chk("idle.hold", rf_addr, 5'd5);

    // Collision: MEM first, ALU queued then drained
    drive(1'b1, 5'd7, 1'b1, 5'd9);
    chk("col.ready", mem_wb_ready, 1'b1);
    tick();
    chk_wr("col.mem", 5'd9);
    chk("col.mdata", rf_data, mem_dat(5'd9));
    chk("col.mwarp", rf_warp, 2'd2);
    chk("col.cnt1", fifo_count, 3'd1);
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    chk_wr("col.alu", 5'd7);
    chk("col.adata", rf_data, alu_dat(5'd7));
    chk("col.cnt0", fifo_count, 3'd0);
    tick();
    chk("col.idle", rf_we, 1'b0);

    // Starvation: three MEM wins, then ALU forced
    drive(1'b1, 5'd4, 1'b1, 5'd10);
    tick();
    chk_wr("stv.c0", 5'd10);
    drive(1'b0, 5'd0, 1'b1, 5'd11);
    chk("stv.rdy1", mem_wb_ready, 1'b1);
    tick();
    chk_wr("stv.c1", 5'd11);
    drive(1'b0, 5'd0, 1'b1, 5'd12);
    chk("stv.rdy2", mem_wb_ready, 1'b1);
    tick();
    chk_wr("stv.c2", 5'd12);
    drive(1'b0, 5'd0, 1'b1, 5'd13);
    chk("stv.rdy3", mem_wb_ready, 1'b0);
    tick();
    chk_wr("stv.force", 5'd4);
    chk("stv.cnt", fifo_count, 3'd0);
    chk("stv.rdy4", mem_wb_ready, 1'b1);
    tick();
    chk_wr("stv.resume", 5'd13);
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    tick();

    // Throttle: two queued ALU results behind MEM traffic
    drive(1'b1, 5'd21, 1'b1, 5'd1);
    tick();
    chk("thr.cnt1", fifo_count, 3'd1);
    chk("thr.off1", alu_throttle, 1'b0);
    drive(1'b1, 5'd22, 1'b1, 5'd2);
    tick();
    chk("thr.cnt2", fifo_count, 3'd2);
    chk("thr.on", alu_throttle, 1'b1);
    drive(1'b0, 5'd0, 1'b1, 5'd3);
    tick();
    chk_wr("thr.mem", 5'd3);
    chk("thr.on2", alu_throttle, 1'b1);
    drive(1'b0, 5'd0, 1'b1, 5'd4);
    chk("thr.rdy", mem_wb_ready, 1'b0);
    tick();
    chk_wr("thr.pop1", 5'd21);
    chk("thr.cnt3", fifo_count, 3'd1);
    chk("thr.off2", alu_throttle, 1'b0);
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    chk_wr("thr.pop2", 5'd22);
    chk("thr.cnt0", fifo_count, 3'd0);
    tick();

    // Overflow: ALU every cycle behind MEM; one forced pop, then a drop
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 5'(i), 1'b1, 5'(16 + i));
      tick();
      chk_wr("ovf.mem", 5'(16 + i));
    end
    chk("ovf.cnt3", fifo_count, 3'd3);
    drive(1'b1, 5'd4, 1'b1, 5'd20);
    tick();
    chk_wr("ovf.force", 5'd1);
    chk("ovf.cnt3b", fifo_count, 3'd3);
    drive(1'b1, 5'd5, 1'b1, 5'd20);
    tick();
    chk_wr("ovf.m20", 5'd20);
    chk("ovf.cnt4", fifo_count, 3'd4);
    chk("ovf.clr", overflow, 1'b0);
    drive(1'b1, 5'd6, 1'b1, 5'd21);
    tick();
    chk("ovf.set", overflow, 1'b1);
    chk("ovf.full", fifo_count, 3'd4);
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    for (int i = 2; i <= 5; i++) begin
      tick();
      chk_wr("ovf.drain", 5'(i));
      chk("ovf.sticky", overflow, 1'b1);
    end
    chk("ovf.empty", fifo_count, 3'd0);
    tick();
    chk("ovf.nodrop", rf_we, 1'b0);

    // Reset mid-operation with three queued results
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(24 + i), 1'b1, 5'(8 + i));
      tick();
    end
    chk("mrst.cnt3", fifo_count, 3'd3);
    rst = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    chk("mrst.ready", mem_wb_ready, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    chk("mrst.we", rf_we, 1'b0);
    chk("mrst.cnt", fifo_count, 3'd0);
    chk("mrst.ovf", overflow, 1'b0);
    chk("mrst.addr", rf_addr, 5'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mrst.stale", rf_we, 1'b0);
    end
    drive(1'b1, 5'd30, 1'b0, 5'd0);
    tick();
    chk_wr("mrst.new", 5'd30);
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Shares the single register-file write port of an SM between two writeback sources.
- The ALU result stream has fixed latency and cannot stall.
- MEM load returns use a valid/ready handshake.
ALU results that lose arbitration are held in a small FIFO. The block drives alu_throttle back to Scheduler, which masks ALU RegWrite grants while the FIFO is near full. A starvation counter guarantees the ALU backlog drains under continuous MEM traffic.

Parameters:
DATA_W, 256, writeback data width (8 lanes x 32b)
REG_AW, 5, register address width
WARP_W, 2, warp id width (4 warps)
FIFO_DEPTH, 4, ALU skid FIFO entries (power of 2, >=2)
THROTTLE_LVL, 2, FIFO occupancy at or above which alu_throttle asserts
STARVE_MAX, 3, consecutive MEM wins with ALU pending before ALU is forced

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
alu_wb_valid  input  1  ALU result present this cycle (no backpressure)
alu_wb_warp  input  WARP_W  ALU result warp id
alu_wb_rd  input  REG_AW  ALU destination register
alu_wb_data  input  DATA_W  ALU result data
mem_wb_valid  input  1  MEM load return valid
mem_wb_ready  output  1  MEM load return accepted when valid&ready
mem_wb_warp  input  WARP_W  MEM warp id
mem_wb_rd  input  REG_AW  MEM destination register
mem_wb_data  input  DATA_W  MEM load data
rf_we  output  1  register-file write enable (registered)
rf_warp  output  WARP_W  write warp id (registered)
rf_addr  output  REG_AW  write register (registered)
rf_data  output  DATA_W  write data (registered)
alu_throttle  output  1  to Scheduler: suppress ALU RegWrite grants
fifo_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  output  1  sticky error: ALU result dropped

Behaviour:
- Reset (rst high at a clock edge): FIFO empty, rd/wr pointers 0, fifo_count=0, starve_cnt=0, rf_we=0, rf_warp/rf_addr/rf_data=0, overflow=0. mem_wb_ready=0 while rst is high. A reset mid-operation discards FIFO contents with no writes issued.
- ALU candidate (alu_pend): the FIFO head if the FIFO is non-empty, else the incoming alu_wb_* if alu_wb_valid, else none. This preserves ALU order.
- force_alu = alu_pend && (starve_cnt == STARVE_MAX). mem_wb_ready = ~rst && ~force_alu. It is independent of mem_wb_valid.
- Winner per cycle:
  - force_alu → ALU.
  - else mem_wb_valid → MEM.
  - else alu_pend → ALU.
  - else idle.
- Write: the winner's warp/rd/data register into rf_* at the next edge with rf_we=1. Latency is 1 cycle from accept to rf_we. When idle, rf_we=0 and the data registers hold their values.
- FIFO pop: the ALU wins and the FIFO is non-empty.
- FIFO push: alu_wb_valid and (the incoming result is not the ALU winner, i.e. FIFO non-empty or MEM won).
- Bypass: FIFO empty, alu_wb_valid, ALU wins → written directly, no push.
- Simultaneous push and pop: allowed at any occupancy including full. Count unchanged.
- Full (count==FIFO_DEPTH) with push and no pop: the result is dropped, overflow sets and stays set until rst. Count stays at FIFO_DEPTH.
- starve_cnt:
  - Clears to 0 when ALU wins or alu_pend=0.
  - Increments when MEM wins while alu_pend=1.
  - Saturates at STARVE_MAX.
- alu_throttle = (fifo_count >= THROTTLE_LVL), from the registered count. With a 1-cycle Scheduler-to-ALU grant path, THROTTLE_LVL <= FIFO_DEPTH-2 prevents overflow.
- Pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.

Test Plan:
1. After rst, ALU-only stream: alu_wb_valid=1 for 5 cycles with rd=1..5, mem idle → rf_we=1 one cycle later with rf_addr 1..5 in order; fifo_count stays 0; mem_wb_ready=1.
2. Collision: ALU rd=7 and MEM rd=9 valid in the same cycle → rf_addr=9 next cycle, then 7 the cycle after; fifo_count goes 1→0; handshake completes with mem_wb_ready=1.
3. Starvation (STARVE_MAX=3): MEM valid continuously, one ALU result rd=4 at cycle 0 → MEM wins cycles 0–2, mem_wb_ready=0 in cycle 3, rf_addr=4 written at cycle 4, MEM resumes at cycle 4.
4. Throttle: MEM valid continuously, ALU valid on 2 consecutive cycles → fifo_count reaches 2 and alu_throttle=1 the next cycle; it deasserts once count drops to 1.
5. Overflow: force 5 ALU results into FIFO_DEPTH=4 with no pops (MEM valid every cycle, STARVE_MAX=7) → 5th dropped, overflow=1 and sticky, count=4; subsequent drain writes only the first 4 in order.
6. Reset mid-operation: fifo_count=3, assert rst for 1 cycle → rf_we=0, count=0, overflow=0, no stale entries written afterwards.
